mem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the shared dual-port instruction/data RAM. It consumes a byte stream (from the UART receiver), frames it, assembles little-endian 32-bit words and writes them into consecutive RAM words starting at address 0 through one RAM port. It holds the core in reset until the image is fully and correctly loaded.

---
 rtl/loader_pkg.sv | 17 +
 rtl/mem_loader_if.sv | 22 ++
 rtl/word_packer.sv | 26 ++
 rtl/mem_loader.sv | 138 +++++++++++++
 tb/tb_mem_loader.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the boot image loader
package loader_pkg;

    localparam int         LEN_W        = 16;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - byte stream in / RAM write port out bundle for mem_loader
interface mem_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_we;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_din, mem_we
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/word_packer.sv
// rtl/word_packer.sv - assembles four bytes into a little-endian 32-bit word
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    // Only three bytes are held; the fourth completes the word combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_valid) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_valid && (r_cnt == 2'd3);
endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - framed byte-stream boot loader into RAM; LOADER_CHECKSUM_EN adds a trailing checksum byte
module mem_loader
    import loader_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         MEM_DEPTH  = 4096,
    parameter int         ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_loader_if.master   bus,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic           cpu_rst_n
);
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MEM_DEPTH);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL_STATE = ST_CSUM;
`else
    localparam loader_state_t TAIL_STATE = ST_DONE;
`endif

    loader_state_t         r_state, w_state_nx;
    logic                  r_rx_ready;
    logic [7:0]            r_len_lo;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_wcnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic                  r_mem_we;
    logic                  r_busy, r_done, r_error, r_cpu_rst_n;

    logic                  w_accept;
    logic [LEN_W-1:0]      w_len;
    logic                  w_last_word;
    logic [31:0]           w_word;
    logic                  w_word_valid;

    assign w_accept    = bus.rx_valid && r_rx_ready;
    assign w_len       = {bus.rx_data, r_len_lo};
    assign w_last_word = (r_wcnt == (r_len - LEN_W'(1)));

    word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte       (bus.rx_data),
        .i_valid      (w_accept && (r_state == ST_DATA)),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= 8'd0;
        end else if (w_accept) begin
            if (r_state == ST_LEN0)
                r_sum <= bus.rx_data;
            else if (r_state == ST_LEN1 || r_state == ST_DATA)
                r_sum <= r_sum + bus.rx_data;
        end
    end
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && bus.rx_data == SYNC_BYTE) w_state_nx = ST_LEN0;
            ST_LEN0: if (w_accept) w_state_nx = ST_LEN1;
            ST_LEN1: begin
                if (w_accept) begin
                    if ({1'b0, w_len} > MAX_LEN)
                        w_state_nx = ST_ERROR;
                    else if (w_len == '0)
                        w_state_nx = TAIL_STATE;
                    else
                        w_state_nx = ST_DATA;
                end
            end
            ST_DATA: if (w_word_valid && w_last_word) w_state_nx = TAIL_STATE;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: if (w_accept) w_state_nx = ((r_sum + bus.rx_data) == 8'd0) ? ST_DONE : ST_ERROR;
`endif
            default: w_state_nx = r_state;
        endcase
    end

    // Status flags follow the next state so they rise the cycle after the deciding byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b0;
            r_len_lo    <= 8'd0;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rx_ready  <= 1'b1;
            r_mem_we    <= w_word_valid;
            r_busy      <= (w_state_nx == ST_LEN0) || (w_state_nx == ST_LEN1) ||
                           (w_state_nx == ST_DATA) || (w_state_nx == ST_CSUM);
            r_done      <= (w_state_nx == ST_DONE);
            r_error     <= (w_state_nx == ST_ERROR);
            r_cpu_rst_n <= (w_state_nx == ST_DONE);
            if (w_accept && r_state == ST_LEN0)
                r_len_lo <= bus.rx_data;
            if (w_accept && r_state == ST_LEN1) begin
                r_len  <= w_len;
                r_wcnt <= '0;
            end
            if (w_word_valid) begin
                r_mem_addr <= r_wcnt[ADDR_WIDTH-1:0];
                r_mem_din  <= w_word;
                r_wcnt     <= r_wcnt + LEN_W'(1);
            end
        end
    end

    assign bus.rx_ready = r_rx_ready;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_we   = r_mem_we;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign cpu_rst_n    = r_cpu_rst_n;
endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader
module tb_mem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done, error, cpu_rst_n;

    mem_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    mem_loader u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_din);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);

        // reset values while rst_n is low
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_rst", bus.rx_ready, 1);

        // two-word frame
        send(8'hA5);
        chk("t1_busy_after_sync", busy, 1);
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
`ifdef LOADER_CHECKSUM_EN
        chk("t1_done_before_csum", done, 0);
        send(8'h9A);
`else
        chk("t1_last_we_with_done", bus.mem_we, 1);
`endif
        chk("t1_done", done, 1);
        chk("t1_cpu_rst_n", cpu_rst_n, 1);
        chk("t1_busy", busy, 0);
        chk("t1_error", error, 0);
        @(negedge clk);
        chk("t1_nwrites", wr_addr.size(), 2);
        chk("t1_addr0", wr_addr[0], 0);
        chk("t1_data0", wr_data[0], 32'h44332211);
        chk("t1_addr1", wr_addr[1], 1);
        chk("t1_data1", wr_data[1], 32'h88776655);
        send(8'hA5); send(8'h01);
        chk("t1_done_sticky", done, 1);
        chk("t1_busy_terminal", busy, 0);
        chk("t1_rx_ready_terminal", bus.rx_ready, 1);

`ifdef LOADER_CHECKSUM_EN
        // bad checksum
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        send(8'h9B);
        chk("t2_error", error, 1);
        chk("t2_done", done, 0);
        chk("t2_cpu_rst_n", cpu_rst_n, 0);
        chk("t2_nwrites", wr_addr.size(), 2);
`endif

        // leading garbage
        do_reset();
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("t3_garbage_busy", busy, 0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef LOADER_CHECKSUM_EN
        send(8'hC7);
`endif
        chk("t3_done", done, 1);
        @(negedge clk);
        chk("t3_nwrites", wr_addr.size(), 1);
        chk("t3_addr0", wr_addr[0], 0);
        chk("t3_data0", wr_data[0], 32'hEFBEADDE);

        // oversize length: 4097 words
        do_reset();
        send(8'hA5); send(8'h01); send(8'h10);
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("t4_nwrites", wr_addr.size(), 0);
        chk("t4_done", done, 0);

        // length exactly MEM_DEPTH is accepted
        do_reset();
        send(8'hA5); send(8'h00); send(8'h10);
        chk("t4b_max_error", error, 0);
        chk("t4b_max_busy", busy, 1);

        // zero-length frame
        do_reset();
        send(8'hA5); send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        chk("t5_done", done, 1);
        chk("t5_cpu_rst_n", cpu_rst_n, 1);
        @(negedge clk);
        chk("t5_nwrites", wr_addr.size(), 0);

        // reset mid-frame, then a fresh frame
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rx_ready", bus.rx_ready, 0);
        chk("t6_rst_mem_addr", bus.mem_addr, 0);
        chk("t6_rst_mem_din", bus.mem_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        send(8'h77); send(8'h88);
        chk("t6_no_resume", busy, 0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
`ifdef LOADER_CHECKSUM_EN
        send(8'hF5);
`endif
        chk("t6_done", done, 1);
        @(negedge clk);
        chk("t6_nwrites", wr_addr.size(), 1);
        chk("t6_addr0", wr_addr[0], 0);
        chk("t6_data0", wr_data[0], 32'h04030201);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
